alu_result_fifo: RTL

// - Downstream stage of the ALU logic/arith units: buffers each registered result word

---
 rtl/alu_result_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - show-ahead result FIFO between the ALU units and their consumer
//
// Buffers ALU result words qualified by IN_VALID and hands them to the consumer
// over an OUT_VALID/OUT_READY handshake. The ALU side has no backpressure, so a
// word arriving while the FIFO is full (and nothing pops) is dropped and the
// sticky OVERFLOW flag is raised until CLR_OVF.
//
// Optional feature macro: ALU_RESULT_FIFO_LEVEL_EN adds the FIFO_LEVEL output.
//
// Ports:
//   CLK        in   clock, all logic on posedge
//   RST        in   asynchronous active-low reset
//   IN_DATA    in   ALU result word
//   IN_VALID   in   IN_DATA valid this cycle
//   OUT_DATA   out  head-of-FIFO word (combinational read)
//   OUT_VALID  out  FIFO not empty
//   OUT_READY  in   consumer accepts OUT_DATA this cycle
//   FULL       out  DEPTH entries stored
//   EMPTY      out  no entries stored
//   OVERFLOW   out  sticky: a valid input word was dropped
//   CLR_OVF    in   synchronous clear of OVERFLOW (an overrun the same cycle wins)
//   FIFO_LEVEL out  occupancy 0..DEPTH (only with ALU_RESULT_FIFO_LEVEL_EN)

module alu_result_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
`ifdef ALU_RESULT_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   FIFO_LEVEL,
`endif
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVF
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra wrap bit distinguishes full from empty when addresses match.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  logic push;
  logic pop;
  logic overrun;

  assign EMPTY     = (wr_ptr == rd_ptr);
  assign FULL      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign OUT_VALID = ~EMPTY;
  assign OUT_DATA  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign pop     = OUT_VALID & OUT_READY;
  // When full, a same-cycle pop frees the head slot so the new word still fits.
  assign push    = IN_VALID & (~FULL | pop);
  assign overrun = IN_VALID & FULL & ~pop;

`ifdef ALU_RESULT_FIFO_LEVEL_EN
  // Modulo-2*DEPTH difference of the wrap-bit pointers is exactly 0..DEPTH.
  assign FIFO_LEVEL = wr_ptr - rd_ptr;
`endif

  // Storage is deliberately not reset; OUT_DATA is only meaningful with OUT_VALID.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Set has priority over clear so a coincident overrun is never lost.
      if (overrun) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_OVF) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule
